sdram_burst_tester: RTL and testbench

Parametrised, synthesizable Avalon-MM burst master that exercises sdram_controller through its dbus_* port. It writes NUM_BURSTS bursts of a deterministic pattern, reads them back and compares every beat in hardware. It reports pass/fail, error count and first failing address, and is used both in simulation and on-board for memory bring-up.

---
 rtl/sdram_burst_tester.sv | 183 ++++++++++++++++++
 tb/tb_sdram_burst_tester.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_tester.sv
// Avalon-MM burst master for SDRAM bring-up: writes NUM_BURSTS bursts of a
// deterministic pattern, reads them back and checks every beat in hardware.
module sdram_burst_tester #(
   parameter int unsigned        DATA_W      = 16,
   parameter int unsigned        ADDR_W      = 25,
   parameter int unsigned        BURST_W     = 7,
   parameter int unsigned        BURST_LEN   = 8,
   parameter int unsigned        NUM_BURSTS  = 4,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
   parameter logic [DATA_W-1:0]  PATTERN_XOR = DATA_W'(16'hA5C3),
   parameter int unsigned        TIMEOUT     = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [15:0]           error_count,
   output logic [ADDR_W-1:0]     first_err_addr,
   output logic [ADDR_W-1:0]     dbus_address,
   output logic [DATA_W-1:0]     dbus_writedata,
   input  logic [DATA_W-1:0]     dbus_readdata,
   output logic [DATA_W/8-1:0]   dbus_byteenable,
   output logic [BURST_W-1:0]    dbus_burstcount,
   output logic                  dbus_read,
   output logic                  dbus_write,
   input  logic                  dbus_waitrequest,
   input  logic                  dbus_readdatavalid
);

   localparam int unsigned       BYTES       = DATA_W / 8;
   localparam int unsigned       B_W         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam int unsigned       K_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned       WD_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [B_W-1:0]    LAST_B      = B_W'(NUM_BURSTS - 1);
   localparam logic [K_W-1:0]    LAST_K      = K_W'(BURST_LEN - 1);
   localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_CMD, S_RD_DATA, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [B_W-1:0]    b_q, b_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [15:0]       err_q, err_d;
   logic [ADDR_W-1:0] fea_q, fea_d;
   logic              timeout_q, timeout_d;
   logic              done_q, done_d;

   logic [31:0]       beat_idx;
   logic [DATA_W-1:0] pattern;
   logic              req_act;

   // Expected beat data D(b,k) is shared by the write and the compare path.
   assign beat_idx = 32'(b_q) * 32'(BURST_LEN) + 32'(k_q);
   assign pattern  = DATA_W'(beat_idx) ^ PATTERN_XOR;

   // NOTE: reset is synchronous, so it lives inside the clocked branch; all
   // state uses non-blocking assignment so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         b_q       <= '0;
         k_q       <= '0;
         addr_q    <= '0;
         wd_q      <= '0;
         err_q     <= '0;
         fea_q     <= '0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         b_q       <= b_d;
         k_q       <= k_d;
         addr_q    <= addr_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
         fea_q     <= fea_d;
         timeout_q <= timeout_d;
         done_q    <= done_d;
      end
   end

   // NOTE: every target gets a hold default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      b_d       = b_q;
      k_d       = k_q;
      addr_d    = addr_q;
      wd_d      = wd_q;
      err_d     = err_q;
      fea_d     = fea_q;
      timeout_d = timeout_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_WR;
               b_d       = '0;
               k_d       = '0;
               addr_d    = BASE_ADDR;
               err_d     = '0;
               fea_d     = '0;
               timeout_d = 1'b0;
            end
         end
         S_WR: begin
            if (!dbus_waitrequest) begin
               if (k_q == LAST_K) begin
                  k_d = '0;
                  if (b_q == LAST_B) begin
                     b_d     = '0;
                     addr_d  = BASE_ADDR;
                     state_d = S_RD_CMD;
                  end else begin
                     b_d    = b_q + 1'b1;
                     addr_d = addr_q + BURST_BYTES;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_RD_CMD: begin
            if (!dbus_waitrequest) begin
               state_d = S_RD_DATA;
               k_d     = '0;
               wd_d    = '0;
            end
         end
         S_RD_DATA: begin
            if (dbus_readdatavalid) begin
               wd_d = '0;
               if (dbus_readdata != pattern) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  if (err_q == 16'd0)    fea_d = addr_q + ADDR_W'(32'(k_q) * BYTES);
               end
               if (k_q == LAST_K) begin
                  k_d = '0;
                  if (b_q == LAST_B) begin
                     state_d = S_DONE;
                  end else begin
                     b_d     = b_q + 1'b1;
                     addr_d  = addr_q + BURST_BYTES;
                     state_d = S_RD_CMD;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE) && (state_q != S_DONE);
   end

   always_comb begin
      dbus_write      = (state_q == S_WR);
      dbus_read       = (state_q == S_RD_CMD);
      req_act         = dbus_write || dbus_read;
      busy            = (state_q == S_WR) || (state_q == S_RD_CMD) || (state_q == S_RD_DATA);
      dbus_address    = addr_q;
      dbus_writedata  = dbus_write ? pattern : '0;
      dbus_byteenable = req_act ? '1 : '0;
      dbus_burstcount = req_act ? BURST_W'(BURST_LEN) : BURST_W'(1);
      done            = done_q;
      pass            = (state_q == S_DONE) && !timeout_q && (err_q == 16'd0);
      timeout         = timeout_q;
      error_count     = err_q;
      first_err_addr  = fea_q;
   end

endmodule

// File: tb/tb_sdram_burst_tester.sv
// Directed bench for sdram_burst_tester: a behavioural Avalon burst slave with
// fault injection (stalls, corrupted beat, dropped beat) and hand-computed checks.
module tb_sdram_burst_tester;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned ADDR_W      = 25;
   localparam int unsigned BURST_W     = 7;
   localparam int unsigned BURST_LEN   = 8;
   localparam int unsigned BURST_BYTES = 16;
   localparam int unsigned TIMEOUT     = 1023;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                busy, done, pass, timeout;
   logic [15:0]         error_count;
   logic [ADDR_W-1:0]   first_err_addr;
   logic [ADDR_W-1:0]   dbus_address;
   logic [DATA_W-1:0]   dbus_writedata;
   logic [DATA_W-1:0]   dbus_readdata = '0;
   logic [DATA_W/8-1:0] dbus_byteenable;
   logic [BURST_W-1:0]  dbus_burstcount;
   logic                dbus_read, dbus_write;
   logic                dbus_waitrequest = 1'b0;
   logic                dbus_readdatavalid = 1'b0;

   always #5 clk = ~clk;

   sdram_burst_tester dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .busy               (busy),
      .done               (done),
      .pass               (pass),
      .timeout            (timeout),
      .error_count        (error_count),
      .first_err_addr     (first_err_addr),
      .dbus_address       (dbus_address),
      .dbus_writedata     (dbus_writedata),
      .dbus_readdata      (dbus_readdata),
      .dbus_byteenable    (dbus_byteenable),
      .dbus_burstcount    (dbus_burstcount),
      .dbus_read          (dbus_read),
      .dbus_write         (dbus_write),
      .dbus_waitrequest   (dbus_waitrequest),
      .dbus_readdatavalid (dbus_readdatavalid)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave model state and fault-injection knobs.
   logic [15:0]       mem [0:255];
   bit                rand_wait = 1'b0;
   bit                corrupt_en = 1'b0;
   bit                drop_en = 1'b0;
   int                wbeats = 0;
   int                rbeats_sent = 0;
   int                rd_accepts = 0;
   int                rd_cnt = 0;
   int                rd_delay = 0;
   int                resp_burst = 0;
   bit                st_w = 1'b0;
   bit                st_r = 1'b0;
   logic [ADDR_W-1:0] st_addr = '0;
   logic [DATA_W-1:0] st_data = '0;

   // Slave drives its inputs on the falling edge for the following rising edge.
   always @(negedge clk) begin
      logic wr_new;
      int   beat;
      if (rst) begin
         rd_cnt             = 0;
         rd_delay           = 0;
         dbus_readdatavalid = 1'b0;
         dbus_readdata      = '0;
         dbus_waitrequest   = 1'b0;
         st_w               = 1'b0;
         st_r               = 1'b0;
      end else begin
         if (st_w) begin
            check("stall_write_held", 32'(dbus_write), 32'd1);
            check("stall_wr_addr", 32'(dbus_address), 32'(st_addr));
            check("stall_wr_data", 32'(dbus_writedata), 32'(st_data));
         end
         if (st_r) begin
            check("stall_read_held", 32'(dbus_read), 32'd1);
            check("stall_rd_addr", 32'(dbus_address), 32'(st_addr));
         end
         dbus_readdatavalid = 1'b0;
         dbus_readdata      = '0;
         if (rd_cnt > 0) begin
            if (rd_delay > 0) begin
               rd_delay--;
            end else begin
               beat = BURST_LEN - rd_cnt;
               rd_cnt--;
               if (!(drop_en && resp_burst == 1 && beat == BURST_LEN - 1)) begin
                  dbus_readdatavalid = 1'b1;
                  dbus_readdata      = mem[8'(resp_burst * BURST_LEN + beat)];
                  if (corrupt_en && resp_burst == 2 && beat == 3)
                     dbus_readdata = dbus_readdata ^ 16'h0001;
                  rbeats_sent++;
               end
            end
         end
         wr_new           = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
         dbus_waitrequest = wr_new;
         if (dbus_write && !wr_new) begin
            check("wr_addr", 32'(dbus_address), 32'((wbeats / BURST_LEN) * BURST_BYTES));
            check("wr_data", 32'(dbus_writedata), 32'(16'(wbeats) ^ 16'hA5C3));
            check("wr_burstcount", 32'(dbus_burstcount), 32'd8);
            check("wr_byteenable", 32'(dbus_byteenable), 32'h3);
            mem[8'(32'(dbus_address >> 1) + (wbeats % BURST_LEN))] = dbus_writedata;
            wbeats++;
         end
         if (dbus_read && !wr_new) begin
            check("rd_addr", 32'(dbus_address), 32'(rd_accepts * BURST_BYTES));
            check("rd_one_outstanding", 32'(rd_cnt), 32'd0);
            resp_burst = rd_accepts;
            rd_accepts++;
            rd_cnt   = BURST_LEN;
            rd_delay = 1;
         end
         st_w    = dbus_write && wr_new;
         st_r    = dbus_read && wr_new;
         st_addr = dbus_address;
         st_data = dbus_writedata;
      end
   end

   task automatic reset_counts();
      wbeats      = 0;
      rbeats_sent = 0;
      rd_accepts  = 0;
   endtask

   task automatic wait_done(input string tag, input int limit, output int cycles);
      bit seen = 1'b0;
      cycles = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         cycles++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic run_pass(input string tag, output int cycles);
      reset_counts();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(tag, 4000, cycles);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: got no summary, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int cyc;
      bit got_mid;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_read", 32'(dbus_read), 32'd0);
      check("rst_write", 32'(dbus_write), 32'd0);
      check("rst_errcnt", 32'(error_count), 32'd0);
      check("rst_fea", 32'(first_err_addr), 32'd0);
      check("rst_addr", 32'(dbus_address), 32'd0);
      check("rst_wdata", 32'(dbus_writedata), 32'd0);
      check("rst_be", 32'(dbus_byteenable), 32'd0);
      check("rst_bc", 32'(dbus_burstcount), 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Ideal slave
      run_pass("ideal", cyc);
      check("ideal_pass", 32'(pass), 32'd1);
      check("ideal_errcnt", 32'(error_count), 32'd0);
      check("ideal_fea", 32'(first_err_addr), 32'd0);
      check("ideal_timeout", 32'(timeout), 32'd0);
      check("ideal_busy_done", 32'(busy), 32'd0);
      check("ideal_wbeats", 32'(wbeats), 32'd32);
      check("ideal_rbeats", 32'(rbeats_sent), 32'd32);
      check("ideal_rbursts", 32'(rd_accepts), 32'd4);
      @(negedge clk);
      check("ideal_done_pulse", 32'(done), 32'd0);
      check("ideal_pass_held", 32'(pass), 32'd1);

      // Random stalls during WR and RD_CMD
      rand_wait = 1'b1;
      run_pass("stall", cyc);
      rand_wait = 1'b0;
      check("stall_pass", 32'(pass), 32'd1);
      check("stall_wbeats", 32'(wbeats), 32'd32);
      check("stall_rbeats", 32'(rbeats_sent), 32'd32);

      // Corrupt beat 3 of burst 2
      corrupt_en = 1'b1;
      run_pass("corrupt", cyc);
      corrupt_en = 1'b0;
      check("corrupt_errcnt", 32'(error_count), 32'd1);
      check("corrupt_fea", 32'(first_err_addr), 32'h26);
      check("corrupt_pass", 32'(pass), 32'd0);
      check("corrupt_timeout", 32'(timeout), 32'd0);

      // Drop last beat of burst 1
      drop_en = 1'b1;
      run_pass("drop", cyc);
      drop_en = 1'b0;
      check("drop_timeout", 32'(timeout), 32'd1);
      check("drop_pass", 32'(pass), 32'd0);
      check("drop_errcnt", 32'(error_count), 32'd0);
      check("drop_latency_min", 32'(cyc >= TIMEOUT), 32'd1);
      @(negedge clk);
      check("drop_timeout_sticky", 32'(timeout), 32'd1);
      check("drop_done_pulse", 32'(done), 32'd0);

      // Reset mid-WR (inside burst 1)
      reset_counts();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got_mid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (wbeats >= 11) begin
            got_mid = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("midrst_reached", 32'(got_mid), 32'd1);
      check("midrst_in_wr", 32'(dbus_write), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_write", 32'(dbus_write), 32'd0);
      check("midrst_read", 32'(dbus_read), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_timeout", 32'(timeout), 32'd0);
      check("midrst_errcnt", 32'(error_count), 32'd0);
      check("midrst_addr", 32'(dbus_address), 32'd0);
      check("midrst_wdata", 32'(dbus_writedata), 32'd0);
      check("midrst_be", 32'(dbus_byteenable), 32'd0);
      check("midrst_bc", 32'(dbus_burstcount), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_pass("rerun", cyc);
      check("rerun_pass", 32'(pass), 32'd1);
      check("rerun_wbeats", 32'(wbeats), 32'd32);

      // Start held high through WR and DONE
      reset_counts();
      corrupt_en = 1'b1;
      @(negedge clk);
      start = 1'b1;
      wait_done("held", 4000, cyc);
      check("held_errcnt", 32'(error_count), 32'd1);
      check("held_pass", 32'(pass), 32'd0);
      check("held_wbeats", 32'(wbeats), 32'd32);
      corrupt_en = 1'b0;
      reset_counts();
      @(negedge clk);
      check("held_restart_busy", 32'(busy), 32'd1);
      check("held_restart_write", 32'(dbus_write), 32'd1);
      check("held_restart_done", 32'(done), 32'd0);
      check("held_restart_errcnt", 32'(error_count), 32'd0);
      start = 1'b0;
      wait_done("held2", 4000, cyc);
      check("held2_pass", 32'(pass), 32'd1);
      check("held2_errcnt", 32'(error_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
